// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the system bus and the UART transmitter; reads use the
// transmitter's rd_en -> data_ready handshake. Define UART_TX_FIFO_LEVEL_EN for o_level/o_almost_full.
module uart_tx_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic                       o_full,
  output logic                       o_overflow,
  input  logic                       i_clr_ovf,
  output logic                       o_valid,
  output logic                       o_empty,
  input  logic                       i_rd_en,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_data_ready
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_almost_full
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_data_ready;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_wr_drop;

  // Acceptance is judged on the registered count, so a full FIFO drops a
  // coincident write even though the read frees a slot this cycle.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_wr_acc  = i_wr_en && !w_full;
  assign w_wr_drop = i_wr_en && w_full;
  assign w_rd_acc  = i_rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_rd_data    <= '0;
      r_data_ready <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_data_ready <= w_rd_acc;
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) begin
        r_rptr    <= r_rptr + 1'b1;
        r_rd_data <= r_mem[r_rptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_wr_drop)      r_overflow <= 1'b1;
      else if (i_clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_valid      = !w_empty;
  assign o_overflow   = r_overflow;
  assign o_rd_data    = r_rd_data;
  assign o_data_ready = r_data_ready;

`ifdef UART_TX_FIFO_LEVEL_EN
  assign o_level       = r_count;
  assign o_almost_full = (r_count >= CW'(AFULL_THRESH));
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: handshake latency, full/overflow, simultaneous
// read/write corner cases, reset mid-transfer and pointer wrap-around.
module tb_uart_tx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst_n;
  logic              i_wr_en;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_full;
  logic              o_overflow;
  logic              i_clr_ovf;
  logic              o_valid;
  logic              o_empty;
  logic              i_rd_en;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_data_ready;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] o_level;
  logic                   o_almost_full;
`endif

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_en      (i_wr_en),
    .i_wr_data    (i_wr_data),
    .o_full       (o_full),
    .o_overflow   (o_overflow),
    .i_clr_ovf    (i_clr_ovf),
    .o_valid      (o_valid),
    .o_empty      (o_empty),
    .i_rd_en      (i_rd_en),
    .o_rd_data    (o_rd_data),
    .o_data_ready (o_data_ready)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .o_level      (o_level),
    .o_almost_full(o_almost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    i_wr_en = 1'b1;
    i_wr_data = d;
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] d);
    i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    chk({tag, "_rdy"}, 32'(o_data_ready), 32'd1);
    chk({tag, "_data"}, 32'(o_rd_data), 32'(d));
  endtask

  logic [7:0] q[$];
  logic [7:0] d;
  logic [7:0] exp_b;
  logic       do_rd;

  initial begin
    rst_n = 1'b0; i_wr_en = 1'b0; i_wr_data = '0; i_rd_en = 1'b0; i_clr_ovf = 1'b0;
    tick(); tick();
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_rdy", 32'(o_data_ready), 32'd0);
    chk("rst_data", 32'(o_rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single byte: valid one cycle after the write, data one cycle after rd_en
    wr_byte(8'hA5);
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_empty", 32'(o_empty), 32'd0);
    tick();
    rd_expect("t1", 8'hA5);
    chk("t1_empty_after", 32'(o_empty), 32'd1);
    tick();
    chk("t1_rdy_pulse", 32'(o_data_ready), 32'd0);
    chk("t1_data_hold", 32'(o_rd_data), 32'hA5);

    // Fill, overflow, back-to-back drain
    for (int i = 0; i < DEPTH; i++) wr_byte(8'(i));
    chk("t2_full", 32'(o_full), 32'd1);
    chk("t2_ovf0", 32'(o_overflow), 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("t2_level", 32'(o_level), 32'd16);
    chk("t2_afull", 32'(o_almost_full), 32'd1);
`endif
    wr_byte(8'h55);
    chk("t2_ovf1", 32'(o_overflow), 32'd1);
    chk("t2_full_keep", 32'(o_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) rd_expect("t2_drain", 8'(i));
    tick();
    chk("t2_rdy_end", 32'(o_data_ready), 32'd0);
    chk("t2_empty_end", 32'(o_empty), 32'd1);

    // Simultaneous read+write on full: write dropped, read served
    i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
    chk("t3_clr", 32'(o_overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) wr_byte(8'(i));
    i_wr_en = 1'b1; i_wr_data = 8'h77; i_rd_en = 1'b1;
    tick();
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    chk("t3_full_rdy", 32'(o_data_ready), 32'd1);
    chk("t3_full_data", 32'(o_rd_data), 32'h00);
    chk("t3_full_ovf", 32'(o_overflow), 32'd1);
    chk("t3_not_full", 32'(o_full), 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("t3_level15", 32'(o_level), 32'd15);
`endif
    for (int i = 1; i < DEPTH; i++) rd_expect("t3_drain", 8'(i));
    tick();
    chk("t3_empty", 32'(o_empty), 32'd1);

    // Simultaneous read+write on empty: no bypass
    i_wr_en = 1'b1; i_wr_data = 8'h3C; i_rd_en = 1'b1;
    tick();
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    chk("t3_empty_rdy", 32'(o_data_ready), 32'd0);
    chk("t3_empty_hold", 32'(o_rd_data), 32'h0F);
    chk("t3_empty_valid", 32'(o_valid), 32'd1);
    rd_expect("t3_bypass", 8'h3C);
    tick();
    chk("t3_empty2", 32'(o_empty), 32'd1);

    // Read on empty ignored; overflow clear priority
    i_rd_en = 1'b1; tick(); i_rd_en = 1'b0;
    chk("t4_rdy", 32'(o_data_ready), 32'd0);
    chk("t4_hold", 32'(o_rd_data), 32'h3C);
    i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
    chk("t4_clr_alone", 32'(o_overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) wr_byte(8'(8'h80 + i));
    i_wr_en = 1'b1; i_wr_data = 8'hEE; i_clr_ovf = 1'b1;
    tick();
    i_wr_en = 1'b0; i_clr_ovf = 1'b0;
    chk("t4_drop_wins", 32'(o_overflow), 32'd1);
    i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
    chk("t4_clr2", 32'(o_overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) rd_expect("t4_drain", 8'(8'h80 + i));
    tick();

    // Wrap-around with random data against a queue model
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      do_rd = (q.size() >= 3);
      exp_b = do_rd ? q[0] : 8'h00;
      i_wr_en = 1'b1; i_wr_data = d; i_rd_en = do_rd;
      tick();
      i_wr_en = 1'b0; i_rd_en = 1'b0;
      if (do_rd) begin
        void'(q.pop_front());
        chk("t5_rdy", 32'(o_data_ready), 32'd1);
        chk("t5_data", 32'(o_rd_data), 32'(exp_b));
      end
      q.push_back(d);
`ifdef UART_TX_FIFO_LEVEL_EN
      chk("t5_level", 32'(o_level), 32'(q.size()));
`endif
    end
    while (q.size() > 0) begin
      exp_b = q.pop_front();
      rd_expect("t5_drain", exp_b);
    end
    tick();
    chk("t5_empty", 32'(o_empty), 32'd1);

`ifdef UART_TX_FIFO_LEVEL_EN
    for (int i = 0; i < 11; i++) wr_byte(8'(i));
    chk("t5_afull11", 32'(o_almost_full), 32'd0);
    wr_byte(8'd11);
    chk("t5_afull12", 32'(o_almost_full), 32'd1);
    for (int i = 0; i < 12; i++) rd_expect("t5_afdrain", 8'(i));
    tick();
`endif

    // Asynchronous reset while a read result is being presented
    wr_byte(8'h11);
    wr_byte(8'h22);
    rd_expect("t6_pre", 8'h11);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_rdy", 32'(o_data_ready), 32'd0);
    chk("t6_rst_empty", 32'(o_empty), 32'd1);
    chk("t6_rst_data", 32'(o_rd_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_valid", 32'(o_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
